sys_pll_lock_supervisor: RTL and testbench
==========================================

# sys_pll_lock_supervisor

Parametrised lock supervisor and reset sequencer for a multi-output system PLL. It drives the PLL's reset and watches its asynchronous `locked` output, which it synchronises and debounces. Once lock is stable it releases N per-domain resets in a staggered order. It detects loss of lock, times out a PLL that never locks, retries automatically, and counts both kinds of event for software.

## Interface
Parameters:
- `N_CLOCKS`, 2: number of PLL output domains, one reset per domain; legal range 1..18.
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchroniser; minimum 2.
- `LOCK_STABLE_CYCLES`, 1024: number of consecutive synchronised-high cycles required before release begins.
- `STAGE_DELAY`, 16: refclk cycles between successive domain reset releases; minimum 1.
- `LOCK_TIMEOUT`, 65536: number of cycles in WAIT_LOCK before the PLL is reset again.
- `PLL_RST_CYCLES`, 8: width of the `pll_rst` pulse in cycles after leaving reset; minimum 1.
- `CNT_W`, 8: width of the event counters.

Ports:
- `refclk`, in, 1: the only clock; the PLL reference clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pll_locked`, in, 1: asynchronous lock indicator from the PLL.
- `force_relock`, in, 1: single-cycle request to reset the PLL and re-sequence all domains.
- `pll_rst`, out, 1: reset to the PLL; registered.
- `domain_rst`, out, N_CLOCKS: per-domain active-high resets; registered.
- `all_ready`, out, 1: high when every domain has been released and the block is in RUN.
- `lock_lost`, out, 1: one-cycle pulse on loss of lock or on a forced relock taken from RELEASE or RUN.
- `relock_count`, out, CNT_W: number of `lock_lost` events; saturates at all-ones.
- `timeout_count`, out, CNT_W: number of WAIT_LOCK timeouts; saturates at all-ones.
- `state`, out, 3: current FSM state for debug. Encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.

## Operation
- `locked_s` is `pll_locked` passed through SYNC_STAGES flops; all decisions use `locked_s` only.
- One shared cycle counter `cnt` is cleared on every state change. A stage index `k` is used only in RELEASE.
- PLL_RST: `pll_rst`=1. When `cnt`==PLL_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - If `locked_s`=1, go to STABLE.
  - Else, when `cnt`==LOCK_TIMEOUT-1, increment `timeout_count` and go to PLL_RST.
  - `force_relock` goes to PLL_RST without counting.
- STABLE:
  - If `locked_s`=0, go back to WAIT_LOCK; no pulse and no count.
  - When `cnt`==LOCK_STABLE_CYCLES-1 with `locked_s`=1, go to RELEASE with k=0.
  - `force_relock` goes to PLL_RST without counting.
- RELEASE:
  - When `cnt`==STAGE_DELAY-1, clear `domain_rst[k]`, clear `cnt`, and increment k.
  - Clearing `domain_rst[N_CLOCKS-1]` moves to RUN; `all_ready` rises on the same edge.
  - Releases are strictly in index order, and a released domain is never reasserted except by an abort.
- RUN: stay while `locked_s`=1 and `force_relock`=0.
- Abort applies in RELEASE or RUN when `locked_s`=0 or `force_relock`=1. On the next edge:
  - all `domain_rst` bits go to 1 and `all_ready` goes to 0;
  - `lock_lost` pulses for one cycle;
  - `relock_count` increments (saturating);
  - the FSM goes to PLL_RST.
- Simultaneous events:
  - `rst` overrides everything.
  - A loss of lock and `force_relock` in the same cycle produce one pulse and one count.
  - A timeout and `locked_s` rising in the same cycle: lock wins, go to STABLE, no count.
- At saturation, counters hold all-ones and do not wrap.

## Timing
- Reset values, held while `rst`=1:
  - `pll_rst`=1, `domain_rst`=all ones, `all_ready`=0, `lock_lost`=0;
  - both counters 0, `state`=PLL_RST, `cnt`=0, k=0;
  - synchroniser flops 0.
- `pll_rst` stays high for exactly PLL_RST_CYCLES edges after `rst` falls, and again for PLL_RST_CYCLES edges after each abort or timeout.
- Latency from a `pll_locked` edge to the FSM reacting is SYNC_STAGES+1 edges.
- `domain_rst[i]` falls (i+1)·STAGE_DELAY edges after RELEASE is entered.
- `rst` asserted mid-sequence reasserts every output to its reset value on the first edge where `rst`=1.

## Test plan
All scenarios use N_CLOCKS=3, SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGE_DELAY=4, LOCK_TIMEOUT=32, PLL_RST_CYCLES=4, CNT_W=4.

- **Clean bring-up.** `pll_locked`=1 throughout; deassert `rst` → `pll_rst` high for 4 cycles; STABLE lasts 8 cycles; `domain_rst` bits 0/1/2 fall 4/8/12 cycles after RELEASE is entered; `all_ready`=1 with bit 2; both counters stay 0.
- **Lock glitch during STABLE.** Drop `pll_locked` for 1 cycle mid-STABLE → FSM returns to WAIT_LOCK; the STABLE count restarts at 0; no `lock_lost`; `relock_count`=0.
- **Timeout and retry.** Hold `pll_locked`=0 → after 32 WAIT_LOCK cycles `pll_rst` pulses for 4 cycles and `timeout_count`=1. Repeat 20 times → `timeout_count` saturates at 15.
- **Loss in RUN.** Drop `pll_locked` in RUN → 3 edges later `domain_rst`=3'b111, `all_ready`=0, one-cycle `lock_lost`, `relock_count`=1, `pll_rst`=1. Restore lock → the full sequence repeats.
- **Abort mid-RELEASE.** Pulse `force_relock` after `domain_rst[0]` has fallen → all bits reassert on the next edge; `relock_count` increments by 1.
- **Reset mid-RUN, with `force_relock` in the same cycle.** Assert `rst` → all outputs and counters return to reset values on that edge; no `lock_lost` pulse.

Source files
------------

// File: rtl/sys_pll_lock_supervisor.sv
// PLL lock supervisor: synchronises and debounces the PLL lock flag,
// releases per-domain resets in order, and retries after timeouts or lock loss.
module sys_pll_lock_supervisor #(
  parameter int N_CLOCKS           = 2,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int PLL_RST_CYCLES     = 8,
  parameter int CNT_W              = 8
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                force_relock,
  output logic                pll_rst,
  output logic [N_CLOCKS-1:0] domain_rst,
  output logic                all_ready,
  output logic                lock_lost,
  output logic [CNT_W-1:0]    relock_count,
  output logic [CNT_W-1:0]    timeout_count,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam int KW = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1;

  localparam logic [31:0] PRC_LAST = 32'(PLL_RST_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] LSC_LAST = 32'(LOCK_STABLE_CYCLES - 1);
  localparam logic [31:0] SD_LAST  = 32'(STAGE_DELAY - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_CLOCKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t st;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [31:0]            cnt;
  logic [KW-1:0]          k;
  logic                   abort;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign state    = st;

  assign abort = ((st == S_RELEASE) || (st == S_RUN))
              && (!locked_s || force_relock);

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      st            <= S_PLL_RST;
      cnt           <= '0;
      k             <= '0;
      pll_rst       <= 1'b1;
      domain_rst    <= '1;
      all_ready     <= 1'b0;
      lock_lost     <= 1'b0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      lock_lost <= 1'b0;
      cnt       <= cnt + 32'd1;
      unique case (st)
        S_PLL_RST: begin
          if (cnt == PRC_LAST) begin
            st      <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          // lock beats a coincident timeout
          if (force_relock) begin
            st      <= S_PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end else if (locked_s) begin
            st  <= S_STABLE;
            cnt <= '0;
          end else if (cnt == TO_LAST) begin
            if (timeout_count != CNT_MAX)
              timeout_count <= timeout_count + 1'b1;
            st      <= S_PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end
        end
        S_STABLE: begin
          if (force_relock) begin
            st      <= S_PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end else if (!locked_s) begin
            st  <= S_WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == LSC_LAST) begin
            st  <= S_RELEASE;
            cnt <= '0;
            k   <= '0;
          end
        end
        S_RELEASE, S_RUN: begin
          if (abort) begin
            domain_rst <= '1;
            all_ready  <= 1'b0;
            lock_lost  <= 1'b1;
            if (relock_count != CNT_MAX)
              relock_count <= relock_count + 1'b1;
            st      <= S_PLL_RST;
            cnt     <= '0;
            k       <= '0;
            pll_rst <= 1'b1;
          end else if (st == S_RUN) begin
            cnt <= '0;
          end else if (cnt == SD_LAST) begin
            domain_rst[k] <= 1'b0;
            cnt           <= '0;
            k             <= k + 1'b1;
            if (k == K_LAST) begin
              st        <= S_RUN;
              all_ready <= 1'b1;
            end
          end
        end
        default: begin
          st         <= S_PLL_RST;
          cnt        <= '0;
          k          <= '0;
          pll_rst    <= 1'b1;
          domain_rst <= '1;
          all_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_pll_lock_supervisor.sv
// Bench for sys_pll_lock_supervisor: directed scenarios plus random
// lock/relock/reset traffic against a phase-and-elapsed-time model.
module tb_sys_pll_lock_supervisor;

  localparam int N   = 3;
  localparam int S   = 2;
  localparam int LSC = 8;
  localparam int SD  = 4;
  localparam int TO  = 32;
  localparam int PRC = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          force_relock = 1'b0;
  logic          pll_rst;
  logic [N-1:0]  domain_rst;
  logic          all_ready;
  logic          lock_lost;
  logic [CW-1:0] relock_count;
  logic [CW-1:0] timeout_count;
  logic [2:0]    state;

  sys_pll_lock_supervisor #(
    .N_CLOCKS(N), .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(LSC),
    .STAGE_DELAY(SD), .LOCK_TIMEOUT(TO), .PLL_RST_CYCLES(PRC),
    .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .force_relock(force_relock), .pll_rst(pll_rst),
    .domain_rst(domain_rst), .all_ready(all_ready),
    .lock_lost(lock_lost), .relock_count(relock_count),
    .timeout_count(timeout_count), .state(state)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail = 0;

  // model: phase (0..4) and edges elapsed in that phase
  int       m_phase = 0;
  int       m_t = 0;
  logic     m_ll = 1'b0;
  int       m_rc = 0;
  int       m_tc = 0;
  logic [S-1:0] m_sh = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_drst();
    logic [N-1:0] d;
    d = '1;
    if (m_phase == 4) d = '0;
    else if (m_phase == 3)
      for (int i = 0; i < N; i++)
        if (m_t >= (i + 1) * SD) d[i] = 1'b0;
    return d;
  endfunction

  task automatic go(input int ph);
    m_phase = ph;
    m_t = 0;
  endtask

  task automatic model_edge();
    logic ls;
    ls = m_sh[S-1];
    m_ll = 1'b0;
    if (rst) begin
      go(0);
      m_rc = 0;
      m_tc = 0;
      m_sh = '0;
      return;
    end
    m_sh = {m_sh[S-2:0], pll_locked};
    case (m_phase)
      0: if (m_t == PRC - 1) go(1); else m_t++;
      1: begin
        if (force_relock) go(0);
        else if (ls) go(2);
        else if (m_t == TO - 1) begin
          m_tc = (m_tc < SAT) ? m_tc + 1 : SAT;
          go(0);
        end else m_t++;
      end
      2: begin
        if (force_relock) go(0);
        else if (!ls) go(1);
        else if (m_t == LSC - 1) go(3);
        else m_t++;
      end
      default: begin
        if (force_relock || !ls) begin
          m_ll = 1'b1;
          m_rc = (m_rc < SAT) ? m_rc + 1 : SAT;
          go(0);
        end else if (m_phase == 3) begin
          m_t++;
          if (m_t == N * SD) go(4);
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    #1;
    check("pll_rst", 32'(pll_rst), 32'(m_phase == 0));
    check("domain_rst", 32'(domain_rst), 32'(exp_drst()));
    check("all_ready", 32'(all_ready), 32'(m_phase == 4));
    check("lock_lost", 32'(lock_lost), 32'(m_ll));
    check("relock_count", 32'(relock_count), 32'(m_rc));
    check("timeout_count", 32'(timeout_count), 32'(m_tc));
    check("state", 32'(state), 32'(m_phase));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int ph, input int t, input string tag);
    int i;
    i = 0;
    while (!(m_phase == ph && m_t >= t) && i < 500) begin
      step();
      i++;
    end
    check(tag, 32'(state), 32'(ph));
  endtask

  initial begin
    int cyc;
    // clean bring-up with lock held throughout
    rst = 1'b1;
    pll_locked = 1'b1;
    run(3);
    check("reset_pll_rst", 32'(pll_rst), 32'd1);
    check("reset_domain_rst", 32'(domain_rst), 32'h7);
    rst = 1'b0;
    cyc = 0;
    while (!all_ready && cyc < 200) begin
      step();
      cyc++;
    end
    check("bringup_latency", 32'(cyc), 32'd25);
    run(5);
    check("bringup_counts", 32'({relock_count, timeout_count}), 32'd0);

    // loss of lock in RUN reacts three edges later
    pll_locked = 1'b0;
    run(2);
    check("loss_no_early", 32'(lock_lost), 32'd0);
    step();
    check("loss_pulse", 32'(lock_lost), 32'd1);
    check("loss_count", 32'(relock_count), 32'd1);
    check("loss_drst", 32'(domain_rst), 32'h7);
    pll_locked = 1'b1;
    wait_phase(4, 0, "relock_run");

    // one-cycle glitch mid-STABLE
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    wait_phase(2, 4, "reach_stable");
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_phase(4, 0, "glitch_run");
    check("glitch_count", 32'(relock_count), 32'd2);

    // forced abort after the first domain is out of reset
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    wait_phase(3, 5, "reach_release");
    check("release_bit0", 32'(domain_rst), 32'h6);
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    check("abort_drst", 32'(domain_rst), 32'h7);
    check("abort_count", 32'(relock_count), 32'd4);

    // timeouts until saturation
    rst = 1'b1;
    pll_locked = 1'b0;
    step();
    rst = 1'b0;
    run(35);
    check("to_not_yet", 32'(timeout_count), 32'd0);
    step();
    check("to_first", 32'(timeout_count), 32'd1);
    check("to_pll_rst", 32'(pll_rst), 32'd1);
    run(19 * (PRC + TO) + 10);
    check("to_saturate", 32'(timeout_count), 32'(SAT));

    // random traffic
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) pll_locked = ~pll_locked;
      force_relock = ($urandom_range(149) == 0);
      rst = ($urandom_range(599) == 0);
      step();
    end
    rst = 1'b0;
    force_relock = 1'b0;

    // reset with a simultaneous relock request in RUN
    pll_locked = 1'b1;
    wait_phase(4, 0, "pre_rst_run");
    rst = 1'b1;
    force_relock = 1'b1;
    step();
    check("rst_no_pulse", 32'(lock_lost), 32'd0);
    check("rst_counts", 32'({relock_count, timeout_count}), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    force_relock = 1'b0;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
